// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: latches a packed BCD word and scans it onto a
// time-multiplexed common-anode 7-segment display, one digit per dwell period.
// New values are double-buffered and take effect only at frame boundaries.
// Optional macro BCD7SEG_LZB_EN enables leading-zero blanking (digit 0 never blanked).

// Per-digit segment decoder, active-low {g,f,e,d,c,b,a}.
module bcd7_dec (
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  // Combinational decode; non-BCD nibbles show a dash (only g lit).
  always_comb begin
    o_seg = 7'b0111111;
    case (i_nib)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = 7'b0111111;
    endcase
    if (i_blank) o_seg = 7'h7F;
  end
endmodule

module bcd_7seg_scanner #(
  parameter int DIGITS  = 5,
  parameter int CLK_DIV = 1000,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  bad_digit
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]           r_div;
  logic [IDX_W-1:0]           r_idx;
  logic [DIGITS-1:0][3:0]     r_disp;
  logic [DIGITS-1:0][3:0]     r_pend;
  logic                       r_pend_v;

  logic [DIGITS-1:0][3:0]     w_in;
  logic                       w_wrap;
  logic                       w_bound;
  logic                       w_bad;
  logic [DIGITS-1:0]          w_blank;
  logic [DIGITS-1:0][6:0]     w_seg_all;

  assign w_in    = bcd_in;
  assign w_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_bound = w_wrap && (r_idx == IDX_W'(DIGITS - 1));

  // Flag any non-BCD nibble in the incoming word.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (w_in[i] > 4'd9) w_bad = 1'b1;
  end

`ifdef BCD7SEG_LZB_EN
  logic [DIGITS-1:0] w_lz;
  // w_lz[i]: nibbles i..DIGITS-1 are all zero; digit 0 always shown.
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_disp[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      w_lz[i] = w_lz[i+1] && (r_disp[i] == 4'd0);
    w_blank    = w_lz;
    w_blank[0] = 1'b0;
  end
`else
  assign w_blank = '0;
`endif

  // One decoder per display position; the scan index picks one below.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd7_dec u_dec (
      .i_nib   (r_disp[g]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg_all[g])
    );
  end

  // Dwell counter and digit index: div wraps at CLK_DIV-1, idx then advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Double buffer: capture into pend, promote to disp only at frame boundary;
  // a valid word on the boundary edge bypasses pend directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      if (bcd_valid) begin
        r_pend   <= w_in;
        r_pend_v <= 1'b1;
      end
      if (w_bound) begin
        if (bcd_valid) begin
          r_disp   <= w_in;
          r_pend_v <= 1'b0;
        end else if (r_pend_v) begin
          r_disp   <= r_pend;
          r_pend_v <= 1'b0;
        end
      end
    end
  end

  // Registered outputs from the pre-edge index and display buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an        <= '1;
      seg       <= 7'h7F;
      bad_digit <= 1'b0;
    end else begin
      an        <= ~(DIGITS'(1) << r_idx);
      seg       <= w_seg_all[r_idx];
      bad_digit <= bcd_valid && w_bad;
    end
  end
endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Self-checking bench for bcd_7seg_scanner (DIGITS=5, CLK_DIV=4).
// Reference model works from the edge count since reset release.
module tb_bcd_7seg_scanner;
  localparam int DIGITS  = 5;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;
`ifdef BCD7SEG_LZB_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*DIGITS-1:0] bcd_in;
  logic                bcd_valid;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                bad_digit;

  int checks = 0;
  int errors = 0;

  bcd_7seg_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .an        (an),
    .seg       (seg),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                           7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  int                  k = 0;          // edges since reset release
  logic [4*DIGITS-1:0] mdisp = '0;
  logic [4*DIGITS-1:0] mq [$];         // words captured in the current frame
  logic [DIGITS-1:0]   e_an  = '1;
  logic [6:0]          e_seg = 7'h7F;
  logic                e_bad = 1'b0;
  bit                  started = 0;

  function automatic logic [6:0] exp_seg(input logic [4*DIGITS-1:0] v, input int pos);
    logic [4*DIGITS-1:0] hi;
    hi = v >> (4 * pos);
`ifdef BCD7SEG_LZB_EN
    if (pos > 0 && hi == '0) return 7'h7F;
`endif
    return lut[hi[3:0]];
  endfunction

  function automatic bit has_bad(input logic [4*DIGITS-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int pos;
    forever begin
      @(posedge clk);
      started = 1;
      if (!rst_n) begin
        k = 0; mdisp = '0; mq.delete();
        e_an = '1; e_seg = 7'h7F; e_bad = 1'b0;
      end else begin
        pos   = (k / CLK_DIV) % DIGITS;
        e_an  = ~(DIGITS'(1) << pos);
        e_seg = exp_seg(mdisp, pos);
        e_bad = bcd_valid && has_bad(bcd_in);
        if (bcd_valid) mq.push_back(bcd_in);
        if ((k % FRAME) == FRAME - 1 && mq.size() > 0) begin
          mdisp = mq[$];
          mq.delete();
        end
        k++;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("bad_digit", bad_digit, e_bad);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_phase(input int t);
    int n;
    n = 0;
    @(negedge clk);
    while ((k % FRAME) != t && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) begin
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", t, k % FRAME);
    end
  endtask

  task automatic pulse(input logic [4*DIGITS-1:0] v);
    bcd_valid = 1'b1;
    bcd_in    = v;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  logic [DIGITS-1:0] an_tbl [6] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};

  initial begin
    logic [4*DIGITS-1:0] v;
    int hold;
    rst_n = 1'b0; bcd_valid = 1'b0; bcd_in = '0;
    repeat (5) @(negedge clk);
    chk("rst_an", an, 5'b11111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_bad", bad_digit, 1'b0);
    rst_n = 1'b1;

    // Scan order after release
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      chk("scan_an", an, an_tbl[j / 4]);
      chk("scan_seg", seg, 7'b1000000);
    end

    // Mid-frame load at idx=2
    wait_phase(8);  pulse(20'h12345);
    wait_phase(13); chk("mid_same_frame", seg, 7'b1000000);
    wait_phase(1);  chk("mid_d0_an", an, 5'b11110); chk("mid_d0", seg, 7'b0010010);
    wait_phase(17); chk("mid_d4_an", an, 5'b01111); chk("mid_d4", seg, 7'b1111001);

    // Last value wins
    wait_phase(3);  pulse(20'h11111);
    wait_phase(10); pulse(20'h00042);
    wait_phase(1);  chk("lvw_d0", seg, 7'b0100100);
    wait_phase(5);  chk("lvw_d1", seg, 7'b0011001);
    wait_phase(9);  chk("lvw_d2", seg, LZ_SEG);
    wait_phase(17); chk("lvw_d4", seg, LZ_SEG);

    // Boundary bypass
    wait_phase(19); pulse(20'h99999);
    wait_phase(1);  chk("byp_d0", seg, 7'b0010000);

    // Invalid digit
    wait_phase(5);  pulse(20'h0000A);
    chk("bad_hi", bad_digit, 1'b1);
    @(negedge clk); chk("bad_lo", bad_digit, 1'b0);
    wait_phase(1);  chk("bad_d0", seg, 7'b0111111);

    // Reset mid-frame with a value pending
    wait_phase(2);  pulse(20'h54321);
    wait_phase(12); rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_an", an, 5'b11111);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_bad", bad_digit, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    wait_phase(1);  chk("mrst_d0_an", an, 5'b11110); chk("mrst_d0", seg, 7'b1000000);
    wait_phase(17); chk("mrst_d4", seg, LZ_SEG);
    wait_phase(1);  chk("mrst_next_d0", seg, 7'b1000000);

    // Randomized traffic, including held-valid bursts and bad nibbles
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < DIGITS; i++)
        v[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0)
        v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if (hold > 0) begin
        hold--;
        bcd_valid = 1'b1;
      end else begin
        bcd_valid = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 40) == 0) hold = $urandom_range(2, 30);
      end
      bcd_in = v;
      if ($urandom_range(0, 400) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(negedge clk);
    end
    bcd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
